h_xor_fold_accum: RTL and testbench
===================================

Name: h_xor_fold_accum

Overview:
- Parametrised, sequential successor to the fixed 16-bit bitwise XOR block.
- Folds a stream of WIDTH-bit words into a running XOR checksum, one word per accepted handshake, under valid/ready flow control.
- Presents the per-frame checksum, word count and parity bit through an output handshake.
- Sits between a word source (memory or stream interface) and integrity-check or compare logic.

Parameters:
WIDTH, 16, data and checksum width in bits (>=1)
SEED, 0, initial accumulator value after reset, clear, and each frame completion (WIDTH bits)
COUNT_W, 8, width of the per-frame word counter (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
clr  input  1  synchronous frame abort; honoured in ACCUM state only
in_valid  input  1  in_data/in_last valid
in_ready  output  1  block can accept a word
in_data  input  WIDTH  word to fold
in_last  input  1  marks final word of frame
out_valid  output  1  frame result available
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  frame checksum = SEED ^ all frame words
out_count  output  COUNT_W  words in frame, saturating
out_parity  output  1  reduction XOR of out_sum
out_ovf  output  1  frame word count exceeded 2^COUNT_W-1

Behaviour:
- Reset (rst=1 at a clock edge) has priority over everything:
  - state=ACCUM, acc=SEED, cnt=0.
  - out_valid=0, out_sum=0, out_count=0, out_parity=0, out_ovf=0.
  - Any partial frame is discarded; no result is emitted for it.
- State machine: two states, ACCUM and HOLD.
- ACCUM:
  - in_ready = ~clr; out_valid=0.
  - clr=1: acc<=SEED, cnt<=0, ovf flag<=0. No word accepted that cycle, because in_ready=0.
  - Accept occurs when in_valid & in_ready:
    - acc<=acc^in_data.
    - cnt<=cnt+1, saturating at 2^COUNT_W-1.
    - If cnt was already all-ones, the internal ovf flag<=1 (sticky for the frame).
  - Accept with in_last=1:
    - out_sum<=acc^in_data.
    - out_count<=saturated cnt+1.
    - out_parity<=^(acc^in_data).
    - out_ovf<=ovf flag | (cnt all-ones).
    - out_valid<=1; go to HOLD.
    - Internal acc<=SEED, cnt<=0, ovf flag<=0 at the same edge.
- HOLD:
  - in_ready=0; out_valid=1.
  - out_* are held stable until the handshake.
  - clr is ignored.
  - out_valid & out_ready: out_valid<=0, go to ACCUM. out_sum/out_count/out_parity/out_ovf keep their last values.
- Latency:
  - Result is visible one cycle after the last-word handshake.
  - Minimum frame period is 1 word + 1 output cycle: the next frame's first word can be accepted the cycle after the output handshake.
- No input buffering. in_ready is a registered-state function (state) ANDed with clr only. It never depends combinationally on in_valid.
- Single-word frames (in_last on the first word) are legal: out_count=1.
- in_last without in_valid has no effect.
- in_data and in_last are ignored when no handshake occurs.
- The fold itself is combinational per word (bitwise XOR of WIDTH lanes). All storage is in acc, cnt, state and output registers.

Test Plan:
- WIDTH=16, SEED=0, out_ready=1; frame 0x1234, 0x00FF, 0xFFFF(last) on consecutive cycles -> one cycle later out_valid=1, out_sum=0xED34, out_count=3, out_parity=1, out_ovf=0; out_valid low on the next cycle; in_ready=0 only during HOLD.
- Single word 0xA5A5 with last -> out_sum=0xA5A5, out_count=1, out_parity=0. Repeat with SEED=0x0F0F -> out_sum=0xAAAA.
- Backpressure: hold out_ready=0 for 5 cycles after a result while in_valid=1 -> out_valid stays 1; out_sum/out_count stay constant; in_ready=0 and no words accepted. Raise out_ready -> out_valid drops next cycle and the next word is accepted the cycle after.
- COUNT_W=2; frame of 5 words 0x0001..0x0005 with last on the 5th -> out_count=3, out_ovf=1, out_sum=0x0001. A following 2-word frame 0x0003, 0x0003 -> out_count=2, out_ovf=0, out_sum=0x0000.
- clr after 2 words of a frame (0x1111, 0x2222), with in_valid=1 in the same cycle -> in_ready=0 and the word is not accepted. Then 0x00F0(last) -> out_sum=0x00F0, out_count=1.
- Reset mid-frame after 3 words, and separately during HOLD -> all outputs 0 and in_ready=1 the cycle after reset deasserts. A subsequent frame 0x0F0F(last) -> out_sum=0x0F0F, out_count=1, with no stale contribution.

Source files
------------

// File: rtl/h_xor_fold_accum_if.sv
// Word-in / frame-result-out handshake bundle for the XOR fold accumulator.
// The master side drives words and accepts results; the slave side is the accumulator.
interface h_xor_fold_accum_if #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_sum;
  logic [COUNT_W-1:0] out_count;
  logic               out_parity;
  logic               out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_parity, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_parity, out_ovf
  );
endinterface

// File: rtl/h_xor_fold_accum.sv
// Folds a word stream into a per-frame XOR checksum; result appears 1 cycle after the last word.
// Backpressure: in_ready drops while a result is held and while clr is asserted; no input buffering.
module h_xor_fold_accum #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] SEED    = '0,
  parameter int               COUNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  h_xor_fold_accum_if.slave   bus
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0]   sum;
    logic [COUNT_W-1:0] count;
    logic               parity;
    logic               ovf;
  } res_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   acc;
  logic [COUNT_W-1:0] cnt;
  logic               ovf;
  res_t               res;

  logic               accept;
  logic               frame_end;
  logic               cnt_full;
  logic [COUNT_W-1:0] cnt_sat;
  logic [WIDTH-1:0]   acc_nxt;

  assign accept    = bus.in_valid & bus.in_ready;
  assign frame_end = accept & bus.in_last;
  assign cnt_full  = &cnt;
  assign cnt_sat   = cnt_full ? cnt : cnt + COUNT_W'(1);
  assign acc_nxt   = acc ^ bus.in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (frame_end) state_nxt = HOLD;
      HOLD:  if (bus.out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      ACCUM: bus.in_ready  = ~clr;
      HOLD:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Accumulator restarts from SEED on frame completion so the next frame has no residue.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= SEED;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (state == ACCUM) begin
      if (clr || frame_end) begin
        acc <= SEED;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (accept) begin
        acc <= acc_nxt;
        cnt <= cnt_sat;
        ovf <= ovf | cnt_full;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
    end else if (state == ACCUM && frame_end) begin
      res.sum    <= acc_nxt;
      res.count  <= cnt_sat;
      res.parity <= ^acc_nxt;
      res.ovf    <= ovf | cnt_full;
    end
  end

  assign bus.out_sum    = res.sum;
  assign bus.out_count  = res.count;
  assign bus.out_parity = res.parity;
  assign bus.out_ovf    = res.ovf;

endmodule

// File: tb/tb_h_xor_fold_accum.sv
// Directed bench: three accumulator variants (default, SEED=0x0F0F, COUNT_W=2) share one stimulus stream.
module tb_h_xor_fold_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  h_xor_fold_accum_if #(.WIDTH(16), .COUNT_W(8)) ifc0 ();
  h_xor_fold_accum_if #(.WIDTH(16), .COUNT_W(8)) ifc1 ();
  h_xor_fold_accum_if #(.WIDTH(16), .COUNT_W(2)) ifc2 ();

  assign ifc0.in_valid  = in_valid;
  assign ifc0.in_data   = in_data;
  assign ifc0.in_last   = in_last;
  assign ifc0.out_ready = out_ready;
  assign ifc1.in_valid  = in_valid;
  assign ifc1.in_data   = in_data;
  assign ifc1.in_last   = in_last;
  assign ifc1.out_ready = out_ready;
  assign ifc2.in_valid  = in_valid;
  assign ifc2.in_data   = in_data;
  assign ifc2.in_last   = in_last;
  assign ifc2.out_ready = out_ready;

  h_xor_fold_accum #(.WIDTH(16), .SEED(16'h0000), .COUNT_W(8))
    dut0 (.clk(clk), .rst(rst), .clr(clr), .bus(ifc0));
  h_xor_fold_accum #(.WIDTH(16), .SEED(16'h0F0F), .COUNT_W(8))
    dut1 (.clk(clk), .rst(rst), .clr(clr), .bus(ifc1));
  h_xor_fold_accum #(.WIDTH(16), .SEED(16'h0000), .COUNT_W(2))
    dut2 (.clk(clk), .rst(rst), .clr(clr), .bus(ifc2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic word(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 16'hDEAD;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; out_ready = 1'b1;
    idle();
    tick(); tick();
    chk("rst_out_valid", 32'(ifc0.out_valid), 32'd0);
    chk("rst_out_sum",   32'(ifc0.out_sum),   32'd0);
    chk("rst_out_count", 32'(ifc0.out_count), 32'd0);
    chk("rst_parity",    32'(ifc0.out_parity), 32'd0);
    chk("rst_ovf",       32'(ifc0.out_ovf),   32'd0);
    chk("rst_in_ready",  32'(ifc0.in_ready),  32'd1);
    rst = 1'b0;
    tick();

    // Three-word frame
    word(16'h1234, 1'b0);
    chk("f1_in_ready_accum", 32'(ifc0.in_ready), 32'd1);
    chk("f1_no_early_valid", 32'(ifc0.out_valid), 32'd0);
    word(16'h00FF, 1'b0);
    word(16'hFFFF, 1'b1);
    chk("f1_valid",  32'(ifc0.out_valid),  32'd1);
    chk("f1_sum",    32'(ifc0.out_sum),    32'hED34);
    chk("f1_count",  32'(ifc0.out_count),  32'd3);
    chk("f1_parity", 32'(ifc0.out_parity), 32'd1);
    chk("f1_ovf",    32'(ifc0.out_ovf),    32'd0);
    chk("f1_in_ready_hold", 32'(ifc0.in_ready), 32'd0);
    chk("f1_seed_sum",  32'(ifc1.out_sum),   32'hE23B);
    chk("f1_cw2_count", 32'(ifc2.out_count), 32'd3);
    chk("f1_cw2_ovf",   32'(ifc2.out_ovf),   32'd0);
    idle();
    tick();
    chk("f1_valid_drop",    32'(ifc0.out_valid), 32'd0);
    chk("f1_in_ready_back", 32'(ifc0.in_ready),  32'd1);
    chk("f1_sum_kept",      32'(ifc0.out_sum),   32'hED34);

    // in_last without in_valid does nothing
    in_last = 1'b1;
    tick();
    chk("last_no_valid", 32'(ifc0.out_valid), 32'd0);
    idle();

    // Single-word frame, both seeds
    word(16'hA5A5, 1'b1);
    chk("sw_sum",       32'(ifc0.out_sum),    32'hA5A5);
    chk("sw_count",     32'(ifc0.out_count),  32'd1);
    chk("sw_parity",    32'(ifc0.out_parity), 32'd0);
    chk("sw_seed_sum",  32'(ifc1.out_sum),    32'hAAAA);
    idle();
    tick();

    // Backpressure: result held, words refused
    out_ready = 1'b0;
    word(16'h0003, 1'b1);
    in_data = 16'h0100;
    in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid",    32'(ifc0.out_valid), 32'd1);
      chk("bp_sum",      32'(ifc0.out_sum),   32'h0003);
      chk("bp_count",    32'(ifc0.out_count), 32'd1);
      chk("bp_in_ready", 32'(ifc0.in_ready),  32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 32'(ifc0.out_valid), 32'd0);
    chk("bp_in_ready",   32'(ifc0.in_ready),  32'd1);
    word(16'h0100, 1'b1);
    chk("bp_next_sum",   32'(ifc0.out_sum),   32'h0100);
    chk("bp_next_count", 32'(ifc0.out_count), 32'd1);
    idle();
    tick();

    // Counter saturation on the COUNT_W=2 instance
    word(16'h0001, 1'b0);
    word(16'h0002, 1'b0);
    word(16'h0003, 1'b0);
    word(16'h0004, 1'b0);
    word(16'h0005, 1'b1);
    chk("sat_cw2_count", 32'(ifc2.out_count), 32'd3);
    chk("sat_cw2_ovf",   32'(ifc2.out_ovf),   32'd1);
    chk("sat_cw2_sum",   32'(ifc2.out_sum),   32'h0001);
    chk("sat_cw8_count", 32'(ifc0.out_count), 32'd5);
    chk("sat_cw8_ovf",   32'(ifc0.out_ovf),   32'd0);
    idle();
    tick();
    word(16'h0003, 1'b0);
    word(16'h0003, 1'b1);
    chk("post_sat_count", 32'(ifc2.out_count), 32'd2);
    chk("post_sat_ovf",   32'(ifc2.out_ovf),   32'd0);
    chk("post_sat_sum",   32'(ifc2.out_sum),   32'h0000);
    idle();
    tick();

    // Frame abort with clr while a word is offered
    word(16'h1111, 1'b0);
    word(16'h2222, 1'b0);
    clr = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h4444;
    in_last  = 1'b0;
    #1;
    chk("clr_in_ready", 32'(ifc0.in_ready), 32'd0);
    tick();
    clr = 1'b0;
    word(16'h00F0, 1'b1);
    chk("clr_sum",   32'(ifc0.out_sum),   32'h00F0);
    chk("clr_count", 32'(ifc0.out_count), 32'd1);
    idle();
    tick();

    // Reset mid-frame
    word(16'h1000, 1'b0);
    word(16'h2000, 1'b0);
    word(16'h4000, 1'b0);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmf_sum",      32'(ifc0.out_sum),   32'd0);
    chk("rmf_count",    32'(ifc0.out_count), 32'd0);
    chk("rmf_valid",    32'(ifc0.out_valid), 32'd0);
    chk("rmf_in_ready", 32'(ifc0.in_ready),  32'd1);
    word(16'h0F0F, 1'b1);
    chk("rmf_next_sum",   32'(ifc0.out_sum),   32'h0F0F);
    chk("rmf_next_count", 32'(ifc0.out_count), 32'd1);
    chk("rmf_seed_sum",   32'(ifc1.out_sum),   32'h0000);
    idle();
    tick();

    // Reset during HOLD
    out_ready = 1'b0;
    word(16'h1234, 1'b1);
    chk("rh_valid_pre", 32'(ifc0.out_valid), 32'd1);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("rh_valid",    32'(ifc0.out_valid),  32'd0);
    chk("rh_sum",      32'(ifc0.out_sum),    32'd0);
    chk("rh_parity",   32'(ifc0.out_parity), 32'd0);
    chk("rh_in_ready", 32'(ifc0.in_ready),   32'd1);
    word(16'h0F0F, 1'b1);
    chk("rh_next_sum",   32'(ifc0.out_sum),   32'h0F0F);
    chk("rh_next_count", 32'(ifc0.out_count), 32'd1);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
